decode_queue: RTL and testbench

Buffered, pipelined instruction-decode stage for the 16-bit processor, parametrised in instruction, register-field and queue size. Raw instructions enter through a valid/ready handshake into an internal FIFO. Each is decoded into register fields, immediate and a one-hot command vector, then held in an output register with its own valid/ready handshake toward execute. The stage also supports a flush from branch/jump resolution and a sticky halt state.

---
 rtl/decode_queue_pkg.sv | 97 +++++++++
 rtl/decode_queue_if.sv | 35 +++
 rtl/decode_queue_fifo.sv | 54 +++++
 rtl/decode_queue.sv | 105 ++++++++++
 tb/tb_decode_queue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// Decode constants and helpers for the 16-bit processor decode stage.
// Opcode map, control codes, one-hot command layout and the opcode-to-command decoder.
package decoder_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ARITH2 = 4'h1;
  localparam logic [3:0] OP_ARITH1 = 4'h2;
  localparam logic [3:0] OP_MOVI   = 4'h3;
  localparam logic [3:0] OP_ADDI   = 4'h4;
  localparam logic [3:0] OP_SUBI   = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h6;
  localparam logic [3:0] OP_STORE  = 4'h7;
  localparam logic [3:0] OP_BEQ    = 4'h8;
  localparam logic [3:0] OP_BGE    = 4'h9;
  localparam logic [3:0] OP_BLE    = 4'hA;
  localparam logic [3:0] OP_BC     = 4'hB;
  localparam logic [3:0] OP_JUMP   = 4'hC;
  localparam logic [3:0] OP_CTRL   = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam logic [11:0] CTRL_STC  = 12'h001;
  localparam logic [11:0] CTRL_STB  = 12'h002;
  localparam logic [11:0] CTRL_RST  = 12'hAAA;
  localparam logic [11:0] CTRL_HALT = 12'hFFF;

  localparam int C_ARITH2  = 0;
  localparam int C_ARITH1  = 1;
  localparam int C_MOVI_LO = 2;
  localparam int C_MOVI_HI = 3;
  localparam int C_ADDI    = 4;
  localparam int C_SUBI    = 5;
  localparam int C_LOAD    = 6;
  localparam int C_STORE   = 7;
  localparam int C_BEQ     = 8;
  localparam int C_BGE     = 9;
  localparam int C_BLE     = 10;
  localparam int C_BC      = 11;
  localparam int C_JUMP    = 12;
  localparam int C_STC     = 13;
  localparam int C_STB     = 14;
  localparam int C_HALT    = 15;
  localparam int C_RST     = 16;
  localparam int C_ILLEGAL = 17;
  localparam int CMD_W     = 18;

  typedef logic [CMD_W-1:0] cmd_t;

  // LSB of register field idx (0=dst, 1=src1, 2=src2), fields packed MSB-first below the opcode
  function automatic int field_lsb(input int instr_w, input int reg_w, input int idx);
    return instr_w - 4 - (idx + 1) * reg_w;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BGE) || (op == OP_BLE) || (op == OP_BC);
  endfunction

  function automatic cmd_t decode_cmd(input logic [3:0] op, input logic [11:0] ctrl,
                                      input logic movi_hi);
    cmd_t c;
    c = '0;
    case (op)
      OP_NOP:    ;
      OP_ARITH2: c[C_ARITH2] = 1'b1;
      OP_ARITH1: c[C_ARITH1] = 1'b1;
      OP_MOVI:   if (movi_hi) c[C_MOVI_HI] = 1'b1; else c[C_MOVI_LO] = 1'b1;
      OP_ADDI:   c[C_ADDI]   = 1'b1;
      OP_SUBI:   c[C_SUBI]   = 1'b1;
      OP_LOAD:   c[C_LOAD]   = 1'b1;
      OP_STORE:  c[C_STORE]  = 1'b1;
      OP_BEQ:    c[C_BEQ]    = 1'b1;
      OP_BGE:    c[C_BGE]    = 1'b1;
      OP_BLE:    c[C_BLE]    = 1'b1;
      OP_BC:     c[C_BC]     = 1'b1;
      OP_JUMP:   c[C_JUMP]   = 1'b1;
      OP_CTRL: begin
        case (ctrl)
          CTRL_STC:  c[C_STC]     = 1'b1;
          CTRL_STB:  c[C_STB]     = 1'b1;
          CTRL_RST:  c[C_RST]     = 1'b1;
          CTRL_HALT: c[C_HALT]    = 1'b1;
          default:   c[C_ILLEGAL] = 1'b1;
        endcase
      end
      default:   c[C_ILLEGAL] = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Upstream instruction handshake plus decoded-instruction handshake toward execute.
interface decode_queue_if #(
  parameter int INSTR_W    = 16,
  parameter int REG_W      = 3,
  parameter int FIFO_DEPTH = 4
);
  import decoder_pkg::*;

  logic                             instr_valid_pi;
  logic [INSTR_W-1:0]               instr_pi;
  logic                             instr_ready_po;
  logic                             flush_pi;
  logic                             dec_valid_po;
  logic                             dec_ready_pi;
  logic [CMD_W-1:0]                 cmd_po;
  logic [2:0]                       alu_func_po;
  logic [REG_W-1:0]                 dst_reg_po;
  logic [REG_W-1:0]                 src_reg1_po;
  logic [REG_W-1:0]                 src_reg2_po;
  logic [INSTR_W-5:0]               imm_po;
  logic                             halted_po;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_po;

  modport master (
    output instr_valid_pi, instr_pi, flush_pi, dec_ready_pi,
    input  instr_ready_po, dec_valid_po, cmd_po, alu_func_po, dst_reg_po,
           src_reg1_po, src_reg2_po, imm_po, halted_po, fifo_count_po
  );

  modport slave (
    input  instr_valid_pi, instr_pi, flush_pi, dec_ready_pi,
    output instr_ready_po, dec_valid_po, cmd_po, alu_func_po, dst_reg_po,
           src_reg1_po, src_reg2_po, imm_po, halted_po, fifo_count_po
  );
endinterface

// File: rtl/decode_queue_fifo.sv
// Raw-instruction queue; power-of-two depth so pointers wrap naturally.
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: FIFO of raw instructions, decode at the FIFO/bypass mux,
// registered decoded output with its own handshake, flush and sticky halt.
module decode_queue
  import decoder_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int REG_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk_pi,
  input logic          rst_pi,
  decode_queue_if.slave q
);
  localparam int CW      = $clog2(FIFO_DEPTH+1);
  localparam int DST_LSB = field_lsb(INSTR_W, REG_W, 0);
  localparam int S1_LSB  = field_lsb(INSTR_W, REG_W, 1);
  localparam int S2_LSB  = field_lsb(INSTR_W, REG_W, 2);

  typedef struct packed {
    cmd_t               cmd;
    logic [2:0]         alu_func;
    logic [REG_W-1:0]   dst;
    logic [REG_W-1:0]   src1;
    logic [REG_W-1:0]   src2;
    logic [INSTR_W-5:0] imm;
  } dec_t;

  logic               full, empty;
  logic [CW-1:0]      count;
  logic [INSTR_W-1:0] head, raw;
  logic [3:0]         op;
  logic               accept, consume, out_free, load_ok, halt_taken;
  logic               bypass, push, pop;
  logic               dec_valid, halted;
  dec_t               dec_nxt, dec_q;

  assign q.instr_ready_po = !full && !halted && !rst_pi;
  assign accept     = q.instr_valid_pi && q.instr_ready_po;
  assign consume    = dec_valid && q.dec_ready_pi;
  assign halt_taken = consume && dec_q.cmd[C_HALT];
  assign out_free   = !dec_valid || consume;
  // the edge that retires a halt must not pull in the instruction behind it
  assign load_ok    = out_free && !halted && !halt_taken;
  assign pop        = load_ok && !empty;
  assign bypass     = accept && empty && load_ok;
  assign push       = accept && !bypass;
  assign raw        = empty ? q.instr_pi : head;
  assign op         = raw[INSTR_W-1 -: 4];

  instr_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_pi),
    .rst   (rst_pi),
    .push  (push),
    .pop   (pop),
    .flush (q.flush_pi),
    .din   (q.instr_pi),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    dec_nxt          = '0;
    dec_nxt.cmd      = decode_cmd(op, raw[11:0], raw[DST_LSB-1]);
    dec_nxt.alu_func = raw[2:0];
    dec_nxt.dst      = raw[DST_LSB +: REG_W];
    dec_nxt.src1     = raw[S1_LSB +: REG_W];
    dec_nxt.src2     = raw[S2_LSB +: REG_W];
    // branches compare dst against src1, so the sources shift up one field
    if (is_branch(op)) begin
      dec_nxt.src1 = raw[DST_LSB +: REG_W];
      dec_nxt.src2 = raw[S1_LSB +: REG_W];
    end
    dec_nxt.imm      = raw[INSTR_W-5:0];
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      dec_valid <= 1'b0;
      dec_q     <= '0;
      halted    <= 1'b0;
    end else begin
      if (halt_taken && !q.flush_pi) halted <= 1'b1;
      if (q.flush_pi) begin
        dec_valid <= 1'b0;
      end else if (pop || bypass) begin
        dec_valid <= 1'b1;
        dec_q     <= dec_nxt;
      end else if (consume) begin
        dec_valid <= 1'b0;
      end
    end
  end

  assign q.dec_valid_po  = dec_valid;
  assign q.cmd_po        = dec_q.cmd;
  assign q.alu_func_po   = dec_q.alu_func;
  assign q.dst_reg_po    = dec_q.dst;
  assign q.src_reg1_po   = dec_q.src1;
  assign q.src_reg2_po   = dec_q.src2;
  assign q.imm_po        = dec_q.imm;
  assign q.halted_po     = halted;
  assign q.fifo_count_po = count;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench: the driver queues hand-computed decodes on accept, monitors pop on consume.
`timescale 1ns/1ps
module tb_decode_queue;
  import decoder_pkg::*;

  typedef struct packed {
    logic [17:0] cmd;
    logic [2:0]  alu;
    logic [3:0]  dst;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] imm;
  } exp_t;

  logic clk_pi = 1'b0;
  logic rst_pi = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, a0, e1, a1;

  decode_queue_if #(.INSTR_W(16), .REG_W(3), .FIFO_DEPTH(4)) q0();
  decode_queue_if #(.INSTR_W(20), .REG_W(4), .FIFO_DEPTH(8)) q1();

  decode_queue #(.INSTR_W(16), .REG_W(3), .FIFO_DEPTH(4)) u_dut (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .q(q0));
  decode_queue #(.INSTR_W(20), .REG_W(4), .FIFO_DEPTH(8)) u_dut2 (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .q(q1));

  always #5 clk_pi = ~clk_pi;

  function automatic exp_t mk(input int c, input logic [2:0] alu, input logic [3:0] d,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] imm);
    exp_t e;
    e.cmd = (c < 0) ? 18'd0 : (18'd1 << c);
    e.alu = alu;
    e.dst = d;
    e.s1  = s1;
    e.s2  = s2;
    e.imm = imm;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // one cycle of upstream drive; expected decode is queued only if the handshake completes
  task automatic cyc(input int sel, input logic [19:0] ins, input exp_t e, input logic fl,
                     output logic acc);
    if (sel == 0) begin
      q0.instr_valid_pi = 1'b1;
      q0.instr_pi       = ins[15:0];
      q0.flush_pi       = fl;
    end else begin
      q1.instr_valid_pi = 1'b1;
      q1.instr_pi       = ins;
    end
    @(negedge clk_pi);
    acc = (sel == 0) ? q0.instr_ready_po : q1.instr_ready_po;
    if (sel == 0 && fl) sb0.delete();
    else if (acc) begin
      if (sel == 0) sb0.push_back(e);
      else          sb1.push_back(e);
    end
    @(posedge clk_pi); #1;
    q0.instr_valid_pi = 1'b0;
    q0.flush_pi       = 1'b0;
    q1.instr_valid_pi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_pi);
    #1;
  endtask

  always @(negedge clk_pi) begin
    if (!rst_pi && q0.dec_valid_po && q0.dec_ready_pi && !q0.flush_pi) begin
      a0 = '{cmd: q0.cmd_po, alu: q0.alu_func_po, dst: {1'b0, q0.dst_reg_po},
             s1: {1'b0, q0.src_reg1_po}, s2: {1'b0, q0.src_reg2_po}, imm: {4'b0, q0.imm_po}};
      total++;
      if (sb0.size() == 0) begin
        bad++;
        $display("FAIL dut0_unexpected: got cmd=%0h imm=%0h want none", a0.cmd, a0.imm);
      end else begin
        e0 = sb0.pop_front();
        if (a0 !== e0) begin
          bad++;
          $display("FAIL dut0_decode: got cmd=%0h alu=%0h d=%0h s1=%0h s2=%0h imm=%0h want cmd=%0h alu=%0h d=%0h s1=%0h s2=%0h imm=%0h",
                   a0.cmd, a0.alu, a0.dst, a0.s1, a0.s2, a0.imm,
                   e0.cmd, e0.alu, e0.dst, e0.s1, e0.s2, e0.imm);
        end
      end
    end
  end

  always @(negedge clk_pi) begin
    if (!rst_pi && q1.dec_valid_po && q1.dec_ready_pi) begin
      a1 = '{cmd: q1.cmd_po, alu: q1.alu_func_po, dst: q1.dst_reg_po,
             s1: q1.src_reg1_po, s2: q1.src_reg2_po, imm: q1.imm_po};
      total++;
      if (sb1.size() == 0) begin
        bad++;
        $display("FAIL dut1_unexpected: got cmd=%0h imm=%0h want none", a1.cmd, a1.imm);
      end else begin
        e1 = sb1.pop_front();
        if (a1 !== e1) begin
          bad++;
          $display("FAIL dut1_decode: got cmd=%0h alu=%0h d=%0h s1=%0h s2=%0h imm=%0h want cmd=%0h alu=%0h d=%0h s1=%0h s2=%0h imm=%0h",
                   a1.cmd, a1.alu, a1.dst, a1.s1, a1.s2, a1.imm,
                   e1.cmd, e1.alu, e1.dst, e1.s1, e1.s2, e1.imm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    q0.instr_valid_pi = 1'b0; q0.instr_pi = '0; q0.flush_pi = 1'b0; q0.dec_ready_pi = 1'b0;
    q1.instr_valid_pi = 1'b0; q1.instr_pi = '0; q1.flush_pi = 1'b0; q1.dec_ready_pi = 1'b0;

    // reset state
    @(negedge clk_pi);
    chk("rst_ready", q0.instr_ready_po, 0);
    chk("rst_valid", q0.dec_valid_po, 0);
    chk("rst_cmd", q0.cmd_po, 0);
    chk("rst_fields", {q0.alu_func_po, q0.dst_reg_po, q0.src_reg1_po, q0.src_reg2_po, q0.imm_po}, 0);
    chk("rst_halted", q0.halted_po, 0);
    chk("rst_count", q0.fifo_count_po, 0);
    @(posedge clk_pi); #1;
    rst_pi = 1'b0;
    @(negedge clk_pi);
    chk("post_rst_ready", q0.instr_ready_po, 1);
    @(posedge clk_pi); #1;

    // back-to-back decode with execute always ready
    q0.dec_ready_pi = 1'b1;
    cyc(0, 'h1A4A, mk(C_ARITH2, 2, 5, 1, 1, 'hA4A), 0, acc);
    chk("lat_valid", q0.dec_valid_po, 1);
    chk("lat_cmd", q0.cmd_po, 1 << C_ARITH2);
    cyc(0, 'h3100, mk(C_MOVI_HI, 0, 0, 4, 0, 'h100), 0, acc); chk("tput_acc1", acc, 1);
    cyc(0, 'h8A40, mk(C_BEQ, 0, 5, 5, 1, 'hA40), 0, acc);      chk("tput_acc2", acc, 1);
    cyc(0, 'hE000, mk(C_ILLEGAL, 0, 0, 0, 0, 'h000), 0, acc);  chk("tput_acc3", acc, 1);
    cyc(0, 'hF003, mk(C_ILLEGAL, 3, 0, 0, 0, 'h003), 0, acc);
    cyc(0, 'hF001, mk(C_STC, 1, 0, 0, 0, 'h001), 0, acc);
    cyc(0, 'hF002, mk(C_STB, 2, 0, 0, 0, 'h002), 0, acc);
    cyc(0, 'hFAAA, mk(C_RST, 2, 5, 2, 5, 'hAAA), 0, acc);
    cyc(0, 'h5123, mk(C_SUBI, 3, 0, 4, 4, 'h123), 0, acc);
    cyc(0, 'h3E00, mk(C_MOVI_LO, 0, 7, 0, 0, 'hE00), 0, acc);
    cyc(0, 'h0000, mk(-1, 0, 0, 0, 0, 'h000), 0, acc);          chk("tput_acc4", acc, 1);
    idle(3);
    chk("stream_drained", sb0.size(), 0);

    // backpressure: one held + four queued, sixth refused
    q0.dec_ready_pi = 1'b0;
    cyc(0, 'h2283, mk(C_ARITH1, 3, 1, 2, 0, 'h283), 0, acc);
    cyc(0, 'h4FC5, mk(C_ADDI, 5, 7, 7, 0, 'hFC5), 0, acc);
    cyc(0, 'h6038, mk(C_LOAD, 0, 0, 0, 7, 'h038), 0, acc);
    cyc(0, 'h9A40, mk(C_BGE, 0, 5, 5, 1, 'hA40), 0, acc);
    cyc(0, 'hC00F, mk(C_JUMP, 7, 0, 0, 1, 'h00F), 0, acc);     chk("bp_acc5", acc, 1);
    cyc(0, 'h0000, mk(-1, 0, 0, 0, 0, 'h000), 0, acc);          chk("bp_acc6", acc, 0);
    chk("bp_count", q0.fifo_count_po, 4);
    chk("bp_ready", q0.instr_ready_po, 0);
    idle(2);
    chk("bp_hold_cmd", q0.cmd_po, 1 << C_ARITH1);
    chk("bp_hold_dst", q0.dst_reg_po, 1);
    q0.dec_ready_pi = 1'b1;
    idle(1);
    chk("drain_count", q0.fifo_count_po, 3);
    idle(4);
    chk("drain_valid", q0.dec_valid_po, 0);
    chk("drain_empty", sb0.size(), 0);

    // halt: 0x1000 stays queued behind the halt
    cyc(0, 'hFFFF, mk(C_HALT, 7, 7, 7, 7, 'hFFF), 0, acc);
    chk("halt_not_yet", q0.halted_po, 0);
    cyc(0, 'h1000, mk(C_ARITH2, 0, 0, 0, 0, 'h000), 0, acc);
    chk("halt_acc", acc, 1);
    chk("halted", q0.halted_po, 1);
    chk("halt_count", q0.fifo_count_po, 1);
    chk("halt_ready", q0.instr_ready_po, 0);
    chk("halt_valid", q0.dec_valid_po, 0);
    idle(3);
    chk("halt_sticky", q0.halted_po, 1);
    chk("halt_count2", q0.fifo_count_po, 1);
    rst_pi = 1'b1; #1;
    chk("halt_rst_halted", q0.halted_po, 0);
    chk("halt_rst_count", q0.fifo_count_po, 0);
    sb0.delete();
    idle(1);
    rst_pi = 1'b0;
    idle(1);
    chk("halt_rst_ready", q0.instr_ready_po, 1);

    // flush: 1 held + 3 queued, flush together with an accept
    q0.dec_ready_pi = 1'b0;
    cyc(0, 'h2283, mk(C_ARITH1, 3, 1, 2, 0, 'h283), 0, acc);
    cyc(0, 'h4FC5, mk(C_ADDI, 5, 7, 7, 0, 'hFC5), 0, acc);
    cyc(0, 'h6038, mk(C_LOAD, 0, 0, 0, 7, 'h038), 0, acc);
    cyc(0, 'h9A40, mk(C_BGE, 0, 5, 5, 1, 'hA40), 0, acc);
    chk("fl_count_pre", q0.fifo_count_po, 3);
    cyc(0, 'hC00F, mk(C_JUMP, 7, 0, 0, 1, 'h00F), 1, acc);
    chk("fl_handshake", acc, 1);
    chk("fl_valid", q0.dec_valid_po, 0);
    chk("fl_count", q0.fifo_count_po, 0);
    q0.dec_ready_pi = 1'b1;
    cyc(0, 'h7E01, mk(C_STORE, 1, 7, 0, 0, 'hE01), 0, acc);
    idle(2);
    chk("fl_after_empty", sb0.size(), 0);

    // async reset between edges
    q0.dec_ready_pi = 1'b0;
    cyc(0, 'h1A4A, mk(C_ARITH2, 2, 5, 1, 1, 'hA4A), 0, acc);
    cyc(0, 'h3100, mk(C_MOVI_HI, 0, 0, 4, 0, 'h100), 0, acc);
    chk("ar_pre_count", q0.fifo_count_po, 1);
    #2 rst_pi = 1'b1;
    #1;
    chk("ar_valid", q0.dec_valid_po, 0);
    chk("ar_cmd", q0.cmd_po, 0);
    chk("ar_fields", {q0.alu_func_po, q0.dst_reg_po, q0.src_reg1_po, q0.src_reg2_po, q0.imm_po}, 0);
    chk("ar_count", q0.fifo_count_po, 0);
    chk("ar_ready", q0.instr_ready_po, 0);
    sb0.delete();
    idle(1);
    rst_pi = 1'b0;
    idle(1);

    // wide configuration: 20-bit instructions, 4-bit registers, 8-deep queue
    q1.dec_ready_pi = 1'b1;
    cyc(1, 20'h1ABCD, mk(C_ARITH2, 5, 10, 11, 12, 'hABCD), 0, acc);
    cyc(1, 20'h85670, mk(C_BEQ, 0, 5, 5, 6, 'h5670), 0, acc);
    cyc(1, 20'h30800, mk(C_MOVI_HI, 0, 0, 8, 0, 'h0800), 0, acc);
    cyc(1, 20'hF1001, mk(C_STC, 1, 1, 0, 0, 'h1001), 0, acc);
    idle(3);
    chk("w_drained", sb1.size(), 0);
    q1.dec_ready_pi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 20'h20000 | 20'(i), mk(C_ARITH1, 3'(i), 0, 0, 0, 16'(i)), 0, acc);
      chk("w_bp_acc", acc, (i < 9) ? 1 : 0);
    end
    chk("w_bp_count", q1.fifo_count_po, 8);
    q1.dec_ready_pi = 1'b1;
    idle(11);
    chk("w_drain_empty", sb1.size(), 0);
    chk("w_drain_valid", q1.dec_valid_po, 0);
    chk("w_drain_count", q1.fifo_count_po, 0);

    chk("sb0_final", sb0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
